// File: rtl/varredura_matriz.sv
// Column-multiplexing scanner for the 5x7 LED matrix: one column per slot,
// blank lead-in per slot, and a frame buffer latched once per frame.
module varredura_matriz #(
    parameter int unsigned DIV_VARREDURA = 50000,
    parameter int unsigned APAGAMENTO    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ligado,
    input  logic [6:0] coluna1_entrada,
    input  logic [6:0] coluna2_entrada,
    input  logic [6:0] coluna3_entrada,
    input  logic [6:0] coluna4_entrada,
    input  logic [6:0] coluna5_entrada,
    output logic [4:0] colunas_saida,
    output logic [6:0] linhas_saida,
    output logic       fim_quadro
);

    localparam int unsigned CW = $clog2(DIV_VARREDURA);
    localparam logic [CW-1:0] C_MAX   = CW'(DIV_VARREDURA - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(APAGAMENTO);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_col;
    logic [6:0]    r_buf [5];

    logic          w_fim_slot;
    logic          w_snapshot;
    logic          w_blank;
    logic [4:0]    w_onehot;
    logic [6:0]    w_linha;

    assign w_fim_slot = (r_cnt == C_MAX);
    assign w_snapshot = (r_col == 3'd0) && (r_cnt == '0);
    assign w_blank    = (r_cnt < C_BLANK);

    always_comb begin
        w_onehot = '0;
        w_linha  = '1;
        case (r_col)
            3'd0: begin w_onehot = 5'b00001; w_linha = r_buf[0]; end
            3'd1: begin w_onehot = 5'b00010; w_linha = r_buf[1]; end
            3'd2: begin w_onehot = 5'b00100; w_linha = r_buf[2]; end
            3'd3: begin w_onehot = 5'b01000; w_linha = r_buf[3]; end
            3'd4: begin w_onehot = 5'b10000; w_linha = r_buf[4]; end
            default: begin w_onehot = '0; w_linha = '1; end
        endcase
    end

    // Outputs register the decode of the current (column, count, buffer),
    // so the buffer loaded at (0,0) first shows at count APAGAMENTO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_col         <= '0;
            for (int unsigned k = 0; k < 5; k++) r_buf[k] <= '1;
            colunas_saida <= '0;
            linhas_saida  <= '1;
            fim_quadro    <= 1'b0;
        end else if (!ligado) begin
            r_cnt         <= '0;
            r_col         <= '0;
            colunas_saida <= '0;
            linhas_saida  <= '1;
            fim_quadro    <= 1'b0;
        end else begin
            if (w_fim_slot) begin
                r_cnt <= '0;
                r_col <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_snapshot) begin
                r_buf[0] <= coluna1_entrada;
                r_buf[1] <= coluna2_entrada;
                r_buf[2] <= coluna3_entrada;
                r_buf[3] <= coluna4_entrada;
                r_buf[4] <= coluna5_entrada;
            end

            colunas_saida <= w_blank ? 5'b00000 : w_onehot;
            linhas_saida  <= w_blank ? 7'b1111111 : w_linha;
            fim_quadro    <= (r_col == 3'd4) && w_fim_slot;
        end
    end

endmodule

// File: tb/tb_varredura_matriz.sv
// Scoreboard bench for varredura_matriz with DIV_VARREDURA=8, APAGAMENTO=2.
module tb_varredura_matriz;

    localparam int DIV   = 8;
    localparam int APAG  = 2;
    localparam int FRAME = 5 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ligado = 1'b1;
    logic [6:0] col_in [5];
    logic [4:0] colunas_saida;
    logic [6:0] linhas_saida;
    logic       fim_quadro;

    varredura_matriz #(
        .DIV_VARREDURA(DIV),
        .APAGAMENTO   (APAG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ligado         (ligado),
        .coluna1_entrada(col_in[0]),
        .coluna2_entrada(col_in[1]),
        .coluna3_entrada(col_in[2]),
        .coluna4_entrada(col_in[3]),
        .coluna5_entrada(col_in[4]),
        .colunas_saida  (colunas_saida),
        .linhas_saida   (linhas_saida),
        .fim_quadro     (fim_quadro)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] col;
        logic [6:0] lin;
        logic       fim;
    } exp_t;

    exp_t    q[$];
    longint  fim_t[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      fim_cnt  = 0;

    // Expected-output timeline: position since the scan (re)started and the
    // pattern set captured at each frame start.
    logic       cur_rst = 1'b1;
    logic       cur_lig = 1'b1;
    int         m_pos   = 0;
    logic [6:0] m_buf [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0b want %0b", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fim_quadro === 1'b1) begin
            fim_cnt++;
            fim_t.push_back($time);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            check("colunas_saida", 32'(colunas_saida), 32'(e.col));
            check("linhas_saida", 32'(linhas_saida), 32'(e.lin));
            check("fim_quadro", 32'(fim_quadro), 32'(e.fim));
            check("onehot0", 32'($onehot0(colunas_saida)), 32'd1);
        end
    end

    task automatic tick(input logic rst, input logic lig);
        exp_t e;
        int   slot;
        int   p;
        @(posedge clk);
        e.col = 5'b00000;
        e.lin = 7'b1111111;
        e.fim = 1'b0;
        if (cur_rst) begin
            m_pos = 0;
            for (int k = 0; k < 5; k++) m_buf[k] = 7'b1111111;
        end else if (!cur_lig) begin
            m_pos = 0;
        end else begin
            slot = (m_pos / DIV) % 5;
            p    = m_pos % DIV;
            if (p >= APAG) begin
                e.col = 5'b00001 << slot;
                e.lin = m_buf[slot];
            end
            e.fim = (slot == 4) && (p == DIV - 1);
            if (m_pos % FRAME == 0)
                for (int k = 0; k < 5; k++) m_buf[k] = col_in[k];
            m_pos++;
        end
        q.push_back(e);
        #1;
        reset   = rst;
        ligado  = lig;
        cur_rst = rst;
        cur_lig = lig;
    endtask

    task automatic run_to(input int target);
        int g;
        g = 0;
        while ((m_pos % FRAME) != target && g < 100) begin
            tick(1'b0, 1'b1);
            g++;
        end
        if (g >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_to: position %0d never reached (at %0d)", target, m_pos % FRAME);
        end
    endtask

    initial begin
        int n0;
        col_in[0] = 7'b0101010;
        col_in[1] = 7'b0011001;
        col_in[2] = 7'b1000001;
        col_in[3] = 7'b0000000;
        col_in[4] = 7'b1100110;

        // Reset held 3 cycles with arbitrary inputs
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);

        // Full scan
        col_in[0] = 7'b0111111;
        col_in[1] = 7'b1011111;
        col_in[2] = 7'b1101111;
        col_in[3] = 7'b1110111;
        col_in[4] = 7'b1111011;
        tick(1'b0, 1'b1);
        repeat (81) tick(1'b0, 1'b1);

        // Three frames of fim_quadro pulses
        n0 = fim_cnt;
        fim_t.delete();
        repeat (120) tick(1'b0, 1'b1);
        check("fim_count", 32'(fim_cnt - n0), 32'd3);
        if (fim_t.size() == 3) begin
            check("fim_spacing_1", 32'(fim_t[1] - fim_t[0]), 32'(FRAME * 10));
            check("fim_spacing_2", 32'(fim_t[2] - fim_t[1]), 32'(FRAME * 10));
        end else begin
            check("fim_pulses", 32'(fim_t.size()), 32'd3);
        end

        // Tear-free: column 3 pattern changes while column 2 is shown
        run_to(12);
        col_in[2] = 7'b0000000;
        repeat (80) tick(1'b0, 1'b1);

        // ligado drop during column 3, new column 1 pattern while idle
        run_to(20);
        repeat (5) tick(1'b0, 1'b0);
        col_in[0] = 7'b0011111;
        repeat (50) tick(1'b0, 1'b1);

        // Reset during column 4
        run_to(28);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        col_in[4] = 7'b1010101;
        repeat (50) tick(1'b0, 1'b1);

        repeat (3) tick(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
